// File: rtl/fu_issue_arbiter_pkg.sv
// rtl/fu_issue_arbiter_pkg.sv - shared types and sizing for the FU issue arbiter
package fu_issue_arbiter_pkg;

   localparam int NUM_RS      = 4;
   localparam int RS_IDX_SIZE = 3;
   localparam int TIMEOUT     = 64;

   localparam int IDX_W = RS_IDX_SIZE + 1;
   localparam int SRC_W = $clog2(NUM_RS);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   localparam logic [IDX_W-1:0] INVALID_RS_INDEX = {1'b1, {RS_IDX_SIZE{1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EXEC  = 2'd2,
      FLUSH = 2'd3
   } arb_state_t;

   // Round-robin successor of a winner, wrapping at NUM_RS rather than at 2**SRC_W.
   function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] winner);
      if (winner == SRC_W'(NUM_RS - 1)) begin
         return '0;
      end
      return winner + 1'b1;
   endfunction

endpackage

// File: rtl/fu_issue_arbiter_rr_picker.sv
// rtl/fu_issue_arbiter_rr_picker.sv - combinational round-robin pick starting at rr_ptr
module fu_issue_arbiter_rr_picker
   import fu_issue_arbiter_pkg::*;
(
   input  logic [NUM_RS-1:0] req,
   input  logic [SRC_W-1:0]  rr_ptr,
   output logic [SRC_W-1:0]  winner,
   output logic              any_req
);

   int idx;

   // Scan farthest offset first so the closest requester to rr_ptr is the last write.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int off = NUM_RS - 1; off >= 0; off--) begin
         idx = (int'(rr_ptr) + off) % NUM_RS;
         if (req[idx[SRC_W-1:0]]) begin
            winner  = idx[SRC_W-1:0];
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fu_issue_arbiter.sv
// rtl/fu_issue_arbiter.sv - shares one FU among NUM_RS reservation stations with flush support
// Optional EXEC watchdog and sticky out_timeout enabled by FU_ISSUE_TIMEOUT_EN.
module fu_issue_arbiter
   import fu_issue_arbiter_pkg::*;
(
   input  logic                         in_clk,
   input  logic                         in_rst,
   input  logic [NUM_RS-1:0][IDX_W-1:0] in_rs_ready_index,
   input  logic                         in_fu_ready,
   input  logic                         in_fu_done,
   input  logic                         in_rob_is_mispred,
   output logic [NUM_RS-1:0]            out_rs_grant,
   output logic                         out_fu_start,
   output logic [SRC_W-1:0]             out_fu_src,
   output logic [IDX_W-1:0]             out_fu_entry_index,
   output logic                         out_fu_kill,
`ifdef FU_ISSUE_TIMEOUT_EN
   output logic                         out_timeout,
`endif
   output logic                         out_busy
);

   arb_state_t        state_q, state_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_RS-1:0] grant_q, grant_d;
   logic              start_q, start_d;
   logic [SRC_W-1:0]  src_q, src_d;
   logic [IDX_W-1:0]  entry_q, entry_d;
   logic              kill_q, kill_d;
   logic              busy_q, busy_d;
`ifdef FU_ISSUE_TIMEOUT_EN
   logic [CNT_W-1:0]  exec_cnt_q, exec_cnt_d;
   logic              timeout_q, timeout_d;
`endif

   logic [NUM_RS-1:0] req;
   logic [SRC_W-1:0]  winner;
   logic              any_req;

   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         req[i] = ~in_rs_ready_index[i][RS_IDX_SIZE];
      end
   end

   fu_issue_arbiter_rr_picker u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = '0;
      start_d    = 1'b0;
      src_d      = src_q;
      entry_d    = entry_q;
      kill_d     = 1'b0;
`ifdef FU_ISSUE_TIMEOUT_EN
      exec_cnt_d = exec_cnt_q;
      timeout_d  = timeout_q;
`endif
      // Mispredict overrides everything; kill only matters if the FU holds work.
      if (in_rob_is_mispred) begin
         state_d = FLUSH;
         kill_d  = (state_q == ISSUE) || (state_q == EXEC);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req && in_fu_ready) begin
                  state_d         = ISSUE;
                  grant_d[winner] = 1'b1;
                  start_d         = 1'b1;
                  src_d           = winner;
                  entry_d         = in_rs_ready_index[winner];
                  rr_ptr_d        = next_ptr(winner);
               end
            end
            ISSUE: begin
               state_d    = EXEC;
`ifdef FU_ISSUE_TIMEOUT_EN
               exec_cnt_d = '0;
`endif
            end
            EXEC: begin
               if (in_fu_done) begin
                  state_d = IDLE;
`ifdef FU_ISSUE_TIMEOUT_EN
               end else if (exec_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_d   = FLUSH;
                  kill_d    = 1'b1;
                  timeout_d = 1'b1;
               end else begin
                  exec_cnt_d = exec_cnt_q + 1'b1;
`endif
               end
            end
            FLUSH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d == ISSUE) || (state_d == EXEC);
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         start_q    <= 1'b0;
         src_q      <= '0;
         entry_q    <= INVALID_RS_INDEX;
         kill_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FU_ISSUE_TIMEOUT_EN
         exec_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         start_q    <= start_d;
         src_q      <= src_d;
         entry_q    <= entry_d;
         kill_q     <= kill_d;
         busy_q     <= busy_d;
`ifdef FU_ISSUE_TIMEOUT_EN
         exec_cnt_q <= exec_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign out_rs_grant       = grant_q;
   assign out_fu_start       = start_q;
   assign out_fu_src         = src_q;
   assign out_fu_entry_index = entry_q;
   assign out_fu_kill        = kill_q;
   assign out_busy           = busy_q;
`ifdef FU_ISSUE_TIMEOUT_EN
   assign out_timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb/tb_fu_issue_arbiter.sv - scoreboard bench for fu_issue_arbiter
module tb_fu_issue_arbiter;
   import fu_issue_arbiter_pkg::*;

   typedef logic [NUM_RS+SRC_W+IDX_W-1:0] exp_t;

   logic                         in_clk = 1'b0;
   logic                         in_rst;
   logic [NUM_RS-1:0][IDX_W-1:0] in_rs_ready_index;
   logic                         in_fu_ready;
   logic                         in_fu_done;
   logic                         in_rob_is_mispred;
   logic [NUM_RS-1:0]            out_rs_grant;
   logic                         out_fu_start;
   logic [SRC_W-1:0]             out_fu_src;
   logic [IDX_W-1:0]             out_fu_entry_index;
   logic                         out_fu_kill;
   logic                         out_busy;
`ifdef FU_ISSUE_TIMEOUT_EN
   logic                         out_timeout;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   always #5 in_clk = ~in_clk;

   fu_issue_arbiter dut (
      .in_clk             (in_clk),
      .in_rst             (in_rst),
      .in_rs_ready_index  (in_rs_ready_index),
      .in_fu_ready        (in_fu_ready),
      .in_fu_done         (in_fu_done),
      .in_rob_is_mispred  (in_rob_is_mispred),
      .out_rs_grant       (out_rs_grant),
      .out_fu_start       (out_fu_start),
      .out_fu_src         (out_fu_src),
      .out_fu_entry_index (out_fu_entry_index),
      .out_fu_kill        (out_fu_kill),
`ifdef FU_ISSUE_TIMEOUT_EN
      .out_timeout        (out_timeout),
`endif
      .out_busy           (out_busy)
   );

   // Every start strobe must match the oldest expected issue.
   always @(negedge in_clk) begin
      if (!in_rst && out_fu_start) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_start: got grant=%b src=%0d idx=%0d, expected no start",
                     out_rs_grant, out_fu_src, out_fu_entry_index);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({out_rs_grant, out_fu_src, out_fu_entry_index} !== e) begin
               miscompares++;
               $display("FAIL issue_match: got {grant,src,idx}=%h, expected %h",
                        {out_rs_grant, out_fu_src, out_fu_entry_index}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic set_none();
      for (int i = 0; i < NUM_RS; i++) in_rs_ready_index[i] = INVALID_RS_INDEX;
   endtask

   task automatic push_exp(input int rs, input int idx);
      logic [NUM_RS-1:0] g;
      g = '0;
      g[rs] = 1'b1;
      sb.push_back({g, SRC_W'(rs), IDX_W'(idx)});
   endtask

   // Two ticks after a start: ISSUE->EXEC, then EXEC->IDLE with done.
   task automatic finish_op();
      tick();
      in_fu_done = 1'b1;
      tick();
      in_fu_done = 1'b0;
   endtask

   task automatic test_reset();
      in_rst = 1'b1;
      set_none();
      in_fu_ready = 1'b1;
      in_fu_done = 1'b0;
      in_rob_is_mispred = 1'b0;
      tick();
      tick();
      vectors++;
      if ({out_rs_grant, out_fu_start, out_fu_src, out_fu_entry_index, out_fu_kill, out_busy} !==
          {{NUM_RS{1'b0}}, 1'b0, {SRC_W{1'b0}}, INVALID_RS_INDEX, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values: grant=%b start=%b src=%0d idx=%b kill=%b busy=%b",
                  out_rs_grant, out_fu_start, out_fu_src, out_fu_entry_index, out_fu_kill, out_busy);
      end
      in_rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (out_fu_start !== 1'b0 || out_busy !== 1'b0 || out_fu_entry_index !== INVALID_RS_INDEX) begin
            miscompares++;
            $display("FAIL idle_no_req: start=%b busy=%b idx=%b, expected 0 0 %b",
                     out_fu_start, out_busy, out_fu_entry_index, INVALID_RS_INDEX);
         end
      end
   endtask

   task automatic test_two_req();
      set_none();
      in_rs_ready_index[1] = IDX_W'(2);
      in_rs_ready_index[3] = IDX_W'(5);
      push_exp(1, 2);
      tick();
      vectors++;
      if (out_fu_start !== 1'b1 || out_rs_grant !== 4'b0010 || out_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL first_grant: start=%b grant=%b busy=%b, expected 1 0010 1",
                  out_fu_start, out_rs_grant, out_busy);
      end
      tick();
      vectors++;
      if (out_fu_start !== 1'b0 || out_rs_grant !== 4'b0000 || out_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL grant_one_cycle: start=%b grant=%b busy=%b, expected 0 0000 1",
                  out_fu_start, out_rs_grant, out_busy);
      end
      in_fu_done = 1'b1;
      tick();
      in_fu_done = 1'b0;
      push_exp(3, 5);
      tick();
      vectors++;
      if (out_fu_start !== 1'b1 || out_fu_src !== SRC_W'(3)) begin
         miscompares++;
         $display("FAIL rr_second: start=%b src=%0d, expected 1 3", out_fu_start, out_fu_src);
      end
      finish_op();
      set_none();
   endtask

   task automatic test_back_to_back();
      int order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NUM_RS; i++) in_rs_ready_index[i] = IDX_W'(i + 1);
      for (int k = 0; k < 5; k++) begin
         push_exp(order[k], order[k] + 1);
         tick();
         vectors++;
         if (out_fu_start !== 1'b1 || out_fu_src !== SRC_W'(order[k])) begin
            miscompares++;
            $display("FAIL b2b_issue_%0d: start=%b src=%0d, expected 1 %0d",
                     k, out_fu_start, out_fu_src, order[k]);
         end
         tick();
         in_fu_done = 1'b1;
         tick();
         in_fu_done = 1'b0;
         if (k == 4) set_none();
      end
   endtask

   task automatic test_mispred();
      // rr_ptr is 1 here: only RS0 requests, so the scan wraps to it.
      set_none();
      in_rs_ready_index[0] = IDX_W'(6);
      push_exp(0, 6);
      tick();
      set_none();
      tick();
      in_rob_is_mispred = 1'b1;
      tick();
      in_rob_is_mispred = 1'b0;
      vectors++;
      if (out_fu_kill !== 1'b1 || out_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL exec_flush_kill: kill=%b busy=%b, expected 1 0", out_fu_kill, out_busy);
      end
      tick();
      vectors++;
      if (out_fu_kill !== 1'b0 || out_fu_start !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_one_cycle: kill=%b start=%b, expected 0 0", out_fu_kill, out_fu_start);
      end
      // Pointer must still be 1 after the flush, so RS1 beats RS0.
      in_rs_ready_index[0] = IDX_W'(4);
      in_rs_ready_index[1] = IDX_W'(3);
      push_exp(1, 3);
      tick();
      set_none();
      tick();
      in_fu_done = 1'b1;
      in_rob_is_mispred = 1'b1;
      tick();
      in_fu_done = 1'b0;
      in_rob_is_mispred = 1'b0;
      vectors++;
      if (out_fu_kill !== 1'b1) begin
         miscompares++;
         $display("FAIL mispred_with_done: kill=%b, expected 1", out_fu_kill);
      end
      tick();
      in_rs_ready_index[2] = IDX_W'(1);
      in_rob_is_mispred = 1'b1;
      tick();
      in_rob_is_mispred = 1'b0;
      set_none();
      vectors++;
      if (out_fu_start !== 1'b0 || out_rs_grant !== 4'b0000 || out_fu_kill !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_mispred: start=%b grant=%b kill=%b, expected 0 0000 0",
                  out_fu_start, out_rs_grant, out_fu_kill);
      end
      tick();
      tick();
   endtask

   task automatic test_fu_ready();
      in_fu_ready = 1'b0;
      in_rs_ready_index[2] = IDX_W'(7);
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if (out_fu_start !== 1'b0 || out_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fu_not_ready_%0d: start=%b busy=%b, expected 0 0", c, out_fu_start, out_busy);
         end
      end
      in_fu_ready = 1'b1;
      push_exp(2, 7);
      tick();
      set_none();
      vectors++;
      if (out_fu_start !== 1'b1) begin
         miscompares++;
         $display("FAIL fu_ready_grant: start=%b, expected 1", out_fu_start);
      end
      finish_op();
   endtask

   task automatic test_single_requester();
      in_rs_ready_index[1] = IDX_W'(0);
      for (int k = 0; k < 3; k++) begin
         push_exp(1, 0);
         tick();
         vectors++;
         if (out_rs_grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_req_%0d: grant=%b, expected 0010", k, out_rs_grant);
         end
         tick();
         in_fu_done = 1'b1;
         tick();
         in_fu_done = 1'b0;
         if (k == 2) set_none();
      end
   endtask

   task automatic test_reset_mid();
      in_rs_ready_index[1] = IDX_W'(1);
      push_exp(1, 1);
      tick();
      set_none();
      tick();
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      vectors++;
      if (out_fu_kill !== 1'b0 || out_busy !== 1'b0 || out_fu_src !== '0 ||
          out_fu_entry_index !== INVALID_RS_INDEX) begin
         miscompares++;
         $display("FAIL reset_mid: kill=%b busy=%b src=%0d idx=%b, expected 0 0 0 %b",
                  out_fu_kill, out_busy, out_fu_src, out_fu_entry_index, INVALID_RS_INDEX);
      end
      // rr_ptr back at 0: RS0 wins over RS3.
      in_rs_ready_index[0] = IDX_W'(2);
      in_rs_ready_index[3] = IDX_W'(3);
      push_exp(0, 2);
      tick();
      set_none();
      vectors++;
      if (out_fu_src !== SRC_W'(0)) begin
         miscompares++;
         $display("FAIL reset_rr_ptr: src=%0d, expected 0", out_fu_src);
      end
      finish_op();
   endtask

`ifdef FU_ISSUE_TIMEOUT_EN
   task automatic test_timeout();
      in_rs_ready_index[2] = IDX_W'(2);
      push_exp(2, 2);
      tick();
      set_none();
      tick();
      for (int c = 0; c < TIMEOUT - 1; c++) tick();
      vectors++;
      if (out_fu_kill !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: kill=%b, expected 0", out_fu_kill);
      end
      tick();
      vectors++;
      if (out_fu_kill !== 1'b1 || out_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_kill: kill=%b timeout=%b, expected 1 1", out_fu_kill, out_timeout);
      end
      tick();
      tick();
      vectors++;
      if (out_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky: timeout=%b, expected 1", out_timeout);
      end
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      vectors++;
      if (out_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_reset: timeout=%b, expected 0", out_timeout);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_two_req();
      test_back_to_back();
      test_mispred();
      test_fu_ready();
      test_single_requester();
      test_reset_mid();
`ifdef FU_ISSUE_TIMEOUT_EN
      test_timeout();
`endif
      tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d expected issues never seen, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Shares one functional unit (FU) between NUM_RS reservation-station instances.
- Each cycle, picks one RS that has a ready entry, using round-robin priority.
- Pulses a consume grant back to the winning RS and a start strobe, with the entry identity, to the FU.
- Sequences the FU through issue/execute and kills in-flight work on ROB mispredict broadcast.

Parameters:
- NUM_RS, 4, number of requesting reservation stations (2..8).
- RS_IDX_SIZE, 3, entry-index width. Each ready index carries one extra MSB used as the invalid flag.
- TIMEOUT, 64, EXEC watchdog limit in cycles (used only with the optional feature).

Ports:
- in_clk  input  1  clock; all state updates on posedge.
- in_rst  input  1  synchronous, active-high reset.
- in_rs_ready_index  input  NUM_RS x (RS_IDX_SIZE+1)  per-RS next-ready entry index; MSB=1 means no ready entry.
- in_fu_ready  input  1  FU can accept a new operation.
- in_fu_done  input  1  FU finished the current operation (one-cycle pulse).
- in_rob_is_mispred  input  1  ROB mispredict broadcast; flush.
- out_rs_grant  output  NUM_RS  one-hot consume pulse to the winning RS.
- out_fu_start  output  1  one-cycle start strobe to the FU.
- out_fu_src  output  $clog2(NUM_RS)  index of the granted RS.
- out_fu_entry_index  output  RS_IDX_SIZE+1  entry index inside the granted RS; MSB always 0 while out_fu_start=1.
- out_fu_kill  output  1  one-cycle abort of the in-flight FU operation.
- out_busy  output  1  high in ISSUE or EXEC.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - out_rs_grant=0, out_fu_start=0, out_fu_src=0, out_fu_entry_index={1'b1,0} (invalid), out_fu_kill=0, out_busy=0.
- A request from RS i is req[i] = ~in_rs_ready_index[i][RS_IDX_SIZE].
- Arbitration:
  - Scan from rr_ptr upward, wrapping modulo NUM_RS; the first i with req[i] wins.
  - After a grant, rr_ptr <= winner+1 (wraps NUM_RS-1 -> 0).
  - rr_ptr is unchanged when there is no grant and on flush.
- FSM:
  - IDLE: if any req and in_fu_ready, go to ISSUE. On that edge, latch the winner into out_fu_src/out_fu_entry_index and set out_rs_grant[winner]=1 and out_fu_start=1 (both visible for exactly the ISSUE cycle).
  - ISSUE: lasts one cycle; go to EXEC. Grant and start drop to 0.
  - EXEC: on in_fu_done, go to IDLE. Requests are ignored in EXEC.
  - FLUSH: lasts one cycle with out_fu_kill=1; go to IDLE.
- Grant latency: a request seen in IDLE gives grant/start on the following cycle. Back-to-back issue is at least 3 cycles apart (ISSUE, EXEC with done, IDLE).
- in_fu_done while in IDLE or ISSUE is ignored.
- Mispredict has priority over every other event. In any state, in_rob_is_mispred=1 sends the FSM to FLUSH and suppresses any grant/start that cycle.
  - out_fu_kill is asserted only if the state was ISSUE or EXEC.
  - Mispredict in IDLE goes to FLUSH with kill=0.
- A mispredict in the same cycle as in_fu_done gives FLUSH.
- in_fu_ready low blocks issue; the FSM stays in IDLE and rr_ptr is held.
- Reset mid-operation forces the reset values on the next edge, with no kill pulse.
- A single requester gets repeated grants; rr_ptr still advances.

Optional Feature:
- Macro: FU_ISSUE_TIMEOUT_EN.
- With the macro defined:
  - Add counter exec_cnt (width $clog2(TIMEOUT)+1), cleared on entry to EXEC and incremented each EXEC cycle without done.
  - When exec_cnt==TIMEOUT-1 and done is absent, go to FLUSH (out_fu_kill=1) and set sticky output out_timeout (1 bit, reset 0, cleared only by in_rst).
  - Under DEBUG_PRINT, also print "(fu_issue_arbiter) timeout".
- Without the macro: no counter and no out_timeout port; EXEC waits indefinitely.

Decomposition:
- Shared data_structures package:
  - Typedef arb_state_t {IDLE, ISSUE, EXEC, FLUSH}.
  - Constants NUM_RS and RS_IDX_SIZE.
  - INVALID_RS_INDEX derived from RS_IDX_SIZE (MSB set).
- Sub-module rr_picker: purely combinational. Inputs are the req vector and rr_ptr; outputs are winner index and any_req.

Test Plan:
- Reset, then idle with all indices MSB=1 and fu_ready=1 -> no grant; outputs stay at reset values; rr_ptr=0.
- req={RS1 idx 2, RS3 idx 5}, fu_ready=1, rr_ptr=0 -> next cycle out_rs_grant=4'b0010, out_fu_src=1, out_fu_entry_index=2, start=1 for one cycle. Then pulse done, keep the same requests -> RS3 (idx 5) is granted next.
- All 4 RS request continuously, done pulsed every EXEC -> grant order 0,1,2,3,0; each issue 3 cycles apart.
- Mispredict during EXEC -> FLUSH for one cycle with kill=1, then IDLE; rr_ptr unchanged. Mispredict in IDLE together with a pending req -> no grant and kill=0.
- fu_ready=0 with RS2 requesting for 5 cycles -> no grant. Raise fu_ready -> grant RS2 the following cycle.
- With FU_ISSUE_TIMEOUT_EN and TIMEOUT=4: issue, withhold done -> kill on the 4th EXEC cycle; out_timeout=1 and stays 1 until in_rst.
